// File: rtl/rf_param_if.sv
// rtl/rf_param_if.sv - write, read and clear signal bundle for rf_param
interface rf_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_a;
  logic [WIDTH-1:0]  rdata_b;
  logic              clr_req;
  logic              busy;
  logic              clr_done;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, clr_req,
    input  rdata_a, rdata_b, busy, clr_done
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, clr_req,
    output rdata_a, rdata_b, busy, clr_done
  );
endinterface

// File: rtl/rf_param.sv
// rtl/rf_param.sv - parametrised 1W/2R register file with sequential clear engine
module rf_param #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  rf_param_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  // One extra bit so the range compare also works when DEPTH is a power of two
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic              wr_ok;
  logic              ra_ok, rb_ok;
  logic [WIDTH-1:0]  rdata_a, rdata_b;
  logic              busy, clr_done;

  // Address is backed by real storage (in range, and not a hardwired r0)
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_X) && !(ZERO_R0 && (a == '0));
  endfunction

  // Decide whether the write port is honoured this cycle; it is locked out while clearing
  always_comb begin
    wr_ok = bus.we && (state_q != CLEAR) && addr_ok(bus.waddr);
    ra_ok = addr_ok(bus.raddr_a);
    rb_ok = addr_ok(bus.raddr_b);
  end

  // Next storage contents: user write, or one entry zeroed by the clear engine
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[bus.waddr] = bus.wdata;
    end
    if (state_q == CLEAR) begin
      mem_d[cnt_q] = '0;
    end
  end

  // Combinational read ports with optional same-cycle write forwarding
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (ra_ok) rdata_a = mem_q[bus.raddr_a];
    if (rb_ok) rdata_b = mem_q[bus.raddr_b];
    if (BYPASS && wr_ok && (bus.waddr == bus.raddr_a)) rdata_a = bus.wdata;
    if (BYPASS && wr_ok && (bus.waddr == bus.raddr_b)) rdata_b = bus.wdata;
  end

  // State, clear counter and storage registers; reset wipes everything and aborts a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  // Clear sequencing: walk the counter 0..DEPTH-1, then a single DONE cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    busy     = (state_q == CLEAR);
    clr_done = (state_q == DONE);
  end

  assign bus.rdata_a  = rdata_a;
  assign bus.rdata_b  = rdata_b;
  assign bus.busy     = busy;
  assign bus.clr_done = clr_done;
endmodule
